if_prefetch_unit: RTL and testbench

- Fetch front end of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to an instruction memory with a valid/ready request channel and variable response latency.
- Buffers returned instructions in a small FIFO and presents one instruction plus PC+4 per cycle to IF/ID.
- Redirects on the branch signal from the EX/MEM side, flushing queued instructions and discarding in-flight responses.

---
 rtl/if_prefetch_unit_if.sv | 32 +++
 rtl/if_prefetch_unit.sv | 152 +++++++++++++++
 tb/tb_if_prefetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response channel used by the fetch front end.
// The request side is a valid/ready handshake. Responses return in request
// order with variable latency and have no backpressure.
interface if_prefetch_unit_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req_valid;
  logic [DATA_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;

  // Fetch unit side: it issues requests and consumes responses.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: it accepts requests and returns instruction words.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_prefetch_unit.sv
// Fetch front end of the 5-stage MIPS pipeline. It owns the fetch PC and
// issues in-order requests to instruction memory. Returned words are queued
// in a small FIFO, and the head instruction is presented to IF/ID together
// with its PC+4. A branch redirects fetch, flushes the queue and discards
// responses that are still in flight.
module if_prefetch_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_unit_if.master  imem,
  input  logic                branch,
  input  logic [DATA_W-1:0]   pc_branch,
  input  logic                stall,
  output logic [DATA_W-1:0]   Instruction_F,
  output logic [DATA_W-1:0]   PcPlus4_F,
  output logic                valid_F
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc4;
  } fetch_entry_t;

  // Architectural state
  logic [DATA_W-1:0] fetch_pc,    fetch_pc_n;
  logic [CNT_W-1:0]  count,       count_n;
  logic [CNT_W-1:0]  outstanding, outstanding_n;
  logic [CNT_W-1:0]  discard,     discard_n;
  logic [PTR_W-1:0]  head,        head_n;
  logic [PTR_W-1:0]  tail,        tail_n;
  logic [PTR_W-1:0]  sq_wr,       sq_wr_n;
  logic [PTR_W-1:0]  sq_rd,       sq_rd_n;

  // Storage: the instruction FIFO and the side queue of PC+4 per in-flight request
  fetch_entry_t      fifo_mem [DEPTH];
  logic [DATA_W-1:0] sq_mem   [DEPTH];

  // Per-cycle events
  logic              req_valid;
  logic              accept;
  logic              rsp_fire;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  occupancy;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] branch_target;
  fetch_entry_t      head_entry;

  // Requests reserve a FIFO slot, so queued plus in-flight never exceeds DEPTH
  always_comb begin
    occupancy     = SUM_W'(count) + SUM_W'(outstanding);
    req_valid     = rst && !branch && (occupancy < SUM_W'(DEPTH));
    accept        = req_valid && imem.imem_req_ready;
    rsp_fire      = imem.imem_rsp_valid && (outstanding != '0);
    push          = rsp_fire && !branch && (discard == '0);
    pop           = valid_F && !stall && !branch;
    pc_plus4      = fetch_pc + DATA_W'(4);
    branch_target = {pc_branch[DATA_W-1:2], 2'b00};
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc;

  // Head-of-queue presentation; a nop with zero PC+4 is shown when empty
  always_comb begin
    valid_F       = (count != '0);
    head_entry    = fifo_mem[head];
    Instruction_F = valid_F ? head_entry.instr : '0;
    PcPlus4_F     = valid_F ? head_entry.pc4   : '0;
  end

  // Next-state computation; a branch overrides pop and push in its cycle
  always_comb begin
    fetch_pc_n    = fetch_pc;
    count_n       = count;
    discard_n     = discard;
    head_n        = head;
    tail_n        = tail;
    sq_wr_n       = sq_wr;
    sq_rd_n       = sq_rd;
    outstanding_n = outstanding + CNT_W'(accept) - CNT_W'(rsp_fire);

    if (accept) begin
      sq_wr_n = sq_wr + PTR_W'(1);
    end
    if (rsp_fire) begin
      sq_rd_n = sq_rd + PTR_W'(1);
    end

    if (branch) begin
      fetch_pc_n = branch_target;
      count_n    = '0;
      head_n     = tail;
      discard_n  = outstanding - CNT_W'(rsp_fire);
    end else begin
      if (accept) begin
        fetch_pc_n = pc_plus4;
      end
      if (rsp_fire && (discard != '0)) begin
        discard_n = discard - CNT_W'(1);
      end
      if (push) begin
        tail_n = tail + PTR_W'(1);
      end
      if (pop) begin
        head_n = head + PTR_W'(1);
      end
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
      sq_wr       <= '0;
      sq_rd       <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      count       <= count_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      head        <= head_n;
      tail        <= tail_n;
      sq_wr       <= sq_wr_n;
      sq_rd       <= sq_rd_n;
    end
  end

  // Data storage; contents are only observed through valid entries, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      sq_mem[sq_wr] <= pc_plus4;
    end
    if (push) begin
      fifo_mem[tail] <= '{instr: imem.imem_rsp_data, pc4: sq_mem[sq_rd]};
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for the fetch prefetch unit. A per-cycle vector table covers
// streaming, stall fill and drain. Hand-written sequences cover the
// redirect, branch-with-response, request backpressure and asynchronous reset
// cases. The memory model returns word(addr) a fixed latency after acceptance.
module tb_if_prefetch_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          branch;
  logic [DW-1:0] pc_branch;
  logic          stall;
  logic [DW-1:0] inst;
  logic [DW-1:0] pc4;
  logic          vf;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  if_prefetch_unit_if #(.DATA_W(DW)) imem ();

  if_prefetch_unit #(
    .DATA_W  (DW),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .branch       (branch),
    .pc_branch    (pc_branch),
    .stall        (stall),
    .Instruction_F(inst),
    .PcPlus4_F    (pc4),
    .valid_F      (vf)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [DW-1:0] a);
    return 32'h2408_0000 + a;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: in-order responses, each due lat cycles after its accept
  typedef struct {
    logic [DW-1:0] addr;
    int            due;
  } pend_t;
  pend_t pend[$];

  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        pend.delete();
        cyc = 0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem.imem_rsp_valid = 1'b1;
          imem.imem_rsp_data  = word(pend[0].addr);
        end else begin
          imem.imem_rsp_valid = 1'b0;
          imem.imem_rsp_data  = '0;
        end
        #2;
        if (rst) begin
          if (imem.imem_rsp_valid) void'(pend.pop_front());
          if (imem.imem_req_valid && imem.imem_req_ready)
            pend.push_back('{addr: imem.imem_req_addr, due: cyc + lat});
          cyc++;
        end
      end
    end
  end

  // Holds reset for a few cycles and releases it on a falling edge (cycle 0)
  task automatic reset_seq(input int l);
    rst       = 1'b0;
    branch    = 1'b0;
    stall     = 1'b0;
    pc_branch = '0;
    imem.imem_req_ready = 1'b0;
    lat = l;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic          stall;
    logic          rv;
    logic [DW-1:0] addr;
    logic          vf;
    logic [DW-1:0] inst;
    logic [DW-1:0] pc4;
  } vec_t;

  vec_t tv [13];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Stream at 1-cycle latency; stall from the first valid, release at cycle 7
    tv[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0,       32'h00};
    tv[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0,       32'h00};
    tv[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, word(32'h0), 32'h04};
    tv[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, word(32'h0), 32'h04};
    tv[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, word(32'h0), 32'h04};
    tv[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, word(32'h0), 32'h04};
    tv[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, word(32'h0), 32'h04};
    tv[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, word(32'h0), 32'h04};
    tv[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, word(32'h4), 32'h08};
    tv[9]  = '{1'b0, 1'b1, 32'h14, 1'b1, word(32'h8), 32'h0C};
    tv[10] = '{1'b0, 1'b1, 32'h18, 1'b1, word(32'hC), 32'h10};
    tv[11] = '{1'b0, 1'b1, 32'h1C, 1'b1, word(32'h10), 32'h14};
    tv[12] = '{1'b0, 1'b1, 32'h20, 1'b1, word(32'h14), 32'h18};

    // Outputs while reset is held
    branch = 1'b0; stall = 1'b0; pc_branch = '0; imem.imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", 32'(vf), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc4", pc4, 32'd0);
    chk("rst_reqv", 32'(imem.imem_req_valid), 32'd0);

    // Vector table
    reset_seq(1);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      stall = tv[i].stall;
      imem.imem_req_ready = 1'b1;
      #2;
      chk($sformatf("vec%0d_reqv", i), 32'(imem.imem_req_valid), 32'(tv[i].rv));
      chk($sformatf("vec%0d_addr", i), imem.imem_req_addr, tv[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(vf), 32'(tv[i].vf));
      chk($sformatf("vec%0d_inst", i), inst, tv[i].inst);
      chk($sformatf("vec%0d_pc4", i), pc4, tv[i].pc4);
    end

    // Redirect to 0x103 with two requests in flight at 3-cycle latency
    reset_seq(3);
    imem.imem_req_ready = 1'b1;
    #2 chk("br_c0_addr", imem.imem_req_addr, 32'h0);
    @(negedge clk);
    #2 chk("br_c1_addr", imem.imem_req_addr, 32'h4);
    @(negedge clk);
    imem.imem_req_ready = 1'b0; branch = 1'b1; pc_branch = 32'h103;
    #2 chk("br_c2_noreq", 32'(imem.imem_req_valid), 32'd0);
    @(negedge clk);
    branch = 1'b0; imem.imem_req_ready = 1'b1;
    #2;
    chk("br_c3_reqv", 32'(imem.imem_req_valid), 32'd1);
    chk("br_c3_addr", imem.imem_req_addr, 32'h100);
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      #2 chk($sformatf("br_c%0d_empty", c), 32'(vf), 32'd0);
    end
    @(negedge clk);
    #2;
    chk("br_c7_valid", 32'(vf), 32'd1);
    chk("br_c7_inst", inst, word(32'h100));
    chk("br_c7_pc4", pc4, 32'h104);
    @(negedge clk);
    #2;
    chk("br_c8_inst", inst, word(32'h104));
    chk("br_c8_pc4", pc4, 32'h108);

    // Branch in the same cycle as a response with one request outstanding
    reset_seq(2);
    imem.imem_req_ready = 1'b1;
    #2 chk("brr_c0_addr", imem.imem_req_addr, 32'h0);
    @(negedge clk);
    imem.imem_req_ready = 1'b0;
    #2 chk("brr_c1_addr", imem.imem_req_addr, 32'h4);
    @(negedge clk);
    branch = 1'b1; pc_branch = 32'h200;
    #2 chk("brr_c2_rsp", 32'(imem.imem_rsp_valid), 32'd1);
    @(negedge clk);
    branch = 1'b0; imem.imem_req_ready = 1'b1;
    #2 chk("brr_c3_addr", imem.imem_req_addr, 32'h200);
    @(negedge clk);
    imem.imem_req_ready = 1'b0;
    #2 chk("brr_c4_empty", 32'(vf), 32'd0);
    @(negedge clk);
    #2 chk("brr_c5_empty", 32'(vf), 32'd0);
    @(negedge clk);
    #2;
    chk("brr_c6_valid", 32'(vf), 32'd1);
    chk("brr_c6_inst", inst, word(32'h200));
    chk("brr_c6_pc4", pc4, 32'h204);

    // Request backpressure, then asynchronous reset mid-stream
    reset_seq(1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      imem.imem_req_ready = 1'b0;
      #2;
      chk($sformatf("rdy_c%0d_reqv", c), 32'(imem.imem_req_valid), 32'd1);
      chk($sformatf("rdy_c%0d_addr", c), imem.imem_req_addr, 32'h0);
    end
    @(negedge clk);
    imem.imem_req_ready = 1'b1;
    #2 chk("rdy_c5_addr", imem.imem_req_addr, 32'h0);
    @(negedge clk);
    #2 chk("rdy_c6_addr", imem.imem_req_addr, 32'h4);
    @(negedge clk);
    #2;
    chk("rdy_c7_inst", inst, word(32'h0));
    chk("rdy_c7_addr", imem.imem_req_addr, 32'h8);
    @(posedge clk);
    #2;
    chk("arst_pre_valid", 32'(vf), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(vf), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_pc4", pc4, 32'd0);
    chk("arst_reqv", 32'(imem.imem_req_valid), 32'd0);
    imem.imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    imem.imem_req_ready = 1'b1;
    #2;
    chk("rel_c0_addr", imem.imem_req_addr, 32'h0);
    chk("rel_c0_valid", 32'(vf), 32'd0);
    @(negedge clk);
    #2 chk("rel_c1_addr", imem.imem_req_addr, 32'h4);
    @(negedge clk);
    #2;
    chk("rel_c2_inst", inst, word(32'h0));
    chk("rel_c2_pc4", pc4, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
